// File: rtl/operand_sequencer.sv
// Operand sequencer: collects an A/B operand pair from a valid/ready stream,
// presents the pair to an external adder, captures the returned sum and flags,
// and holds the result until the consumer accepts it.
//
// state  | meaning
// -------+---------------------------------------------------------------
// LOAD_A | idle, waiting for the A operand word
// LOAD_B | A captured, waiting for the B operand word
// EXEC   | operands stable on op_a/op_b for one cycle, adder result sampled
// HOLD   | result valid, waiting for res_ready
module operand_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    input  logic [N-1:0] sum_in,
    input  logic         cf_in,
    input  logic         ovf_in,
    output logic [N-1:0] result,
    output logic         res_cf,
    output logic         res_ovf,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         sticky_cf,
    output logic         sticky_ovf,
    input  logic         clr_sticky,
    output logic [7:0]   op_count,
    output logic         busy
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept_a;
    logic   accept_b;

    // Next-state and state-decoded outputs; outputs depend on state only,
    // so nothing downstream sees a combinational path from din/din_valid.
    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        accept_a   = 1'b0;
        accept_b   = 1'b0;
        case (state)
            LOAD_A: begin
                din_ready = 1'b1;
                busy      = 1'b0;
                accept_a  = din_valid;
                if (din_valid) state_next = LOAD_B;
            end
            LOAD_B: begin
                din_ready = 1'b1;
                accept_b  = din_valid;
                if (din_valid) state_next = EXEC;
            end
            EXEC: begin
                state_next = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_next = LOAD_A;
            end
            default: begin
                state_next = LOAD_A;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) state <= LOAD_A;
        else     state <= state_next;
    end

    // Operand registers; each keeps its value until its own next accept.
    always_ff @(posedge clk) begin
        if (clr) begin
            op_a <= '0;
            op_b <= '0;
        end else begin
            if (accept_a) op_a <= din;
            if (accept_b) op_b <= din;
        end
    end

    // Result capture and operation count at the close of EXEC.
    always_ff @(posedge clk) begin
        if (clr) begin
            result   <= '0;
            res_cf   <= 1'b0;
            res_ovf  <= 1'b0;
            op_count <= 8'd0;
        end else if (state == EXEC) begin
            result   <= sum_in;
            res_cf   <= cf_in;
            res_ovf  <= ovf_in;
            op_count <= op_count + 8'd1;
        end
    end

    // Sticky flags: a set from EXEC takes priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            sticky_cf  <= 1'b0;
            sticky_ovf <= 1'b0;
        end else begin
            if (state == EXEC && cf_in)  sticky_cf  <= 1'b1;
            else if (clr_sticky)         sticky_cf  <= 1'b0;
            if (state == EXEC && ovf_in) sticky_ovf <= 1'b1;
            else if (clr_sticky)         sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: models the downstream 8-bit adder and keeps a
// scoreboard of expected results, pushed when operands are sent and popped
// when the sequencer presents a result.
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] op_a, op_b;
    logic [7:0] sum_in;
    logic       cf_in, ovf_in;
    logic [7:0] result;
    logic       res_cf, res_ovf, res_valid, res_ready;
    logic       sticky_cf, sticky_ovf, clr_sticky;
    logic [7:0] op_count;
    logic       busy;

    typedef struct {
        logic [7:0] r;
        logic       cf;
        logic       ovf;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_count;

    operand_sequencer #(.N(8)) dut (
        .clk(clk), .clr(clr), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .op_a(op_a), .op_b(op_b),
        .sum_in(sum_in), .cf_in(cf_in), .ovf_in(ovf_in),
        .result(result), .res_cf(res_cf), .res_ovf(res_ovf),
        .res_valid(res_valid), .res_ready(res_ready),
        .sticky_cf(sticky_cf), .sticky_ovf(sticky_ovf),
        .clr_sticky(clr_sticky), .op_count(op_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Downstream adder: unsigned carry, two's-complement overflow.
    logic [8:0] s9;
    always_comb begin
        s9     = {1'b0, op_a} + {1'b0, op_b};
        sum_in = s9[7:0];
        cf_in  = s9[8];
        ovf_in = (op_a[7] == op_b[7]) && (s9[7] != op_a[7]);
    end

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [8:0] t;
        t     = {1'b0, a} + {1'b0, b};
        e.r   = t[7:0];
        e.cf  = t[8];
        e.ovf = (a[7] == b[7]) && (t[7] != a[7]);
        return e;
    endfunction

    task automatic send(input logic [7:0] w);
        int n = 0;
        din       = w;
        din_valid = 1'b1;
        while (!din_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!din_ready) begin
            errors++;
            $display("FAIL send_ready: din_ready=%b after %0d cycles, required 1", din_ready, n);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    // Returns with the B word just accepted (sequencer in EXEC).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b);
        q.push_back(model(a, b));
        send(a);
        send(b);
    endtask

    // Waits for res_valid, compares against the scoreboard head, then lets
    // the result drain (res_ready assumed high on entry).
    task automatic expect_result(input string name, input int exp_lat);
        int   n = 0;
        exp_t e;
        while (!res_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!res_valid || n != exp_lat) begin
            errors++;
            $display("FAIL %s latency: res_valid=%b after %0d cycles, required 1 after %0d", name, res_valid, n, exp_lat);
        end
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: queue empty, required an entry", name);
        end else begin
            e = q.pop_front();
            exp_count = exp_count + 8'd1;
            checks++;
            if (result !== e.r) begin
                errors++;
                $display("FAIL %s result: got %h, required %h", name, result, e.r);
            end
            checks++;
            if (res_cf !== e.cf) begin
                errors++;
                $display("FAIL %s res_cf: got %b, required %b", name, res_cf, e.cf);
            end
            checks++;
            if (res_ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s res_ovf: got %b, required %b", name, res_ovf, e.ovf);
            end
            checks++;
            if (op_count !== exp_count) begin
                errors++;
                $display("FAIL %s op_count: got %0d, required %0d", name, op_count, exp_count);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s return: busy=%b din_ready=%b, required 0/1", name, busy, din_ready);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (op_a !== 8'h00 || op_b !== 8'h00 || result !== 8'h00 || res_cf !== 1'b0 ||
            res_ovf !== 1'b0 || sticky_cf !== 1'b0 || sticky_ovf !== 1'b0 ||
            op_count !== 8'd0 || res_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: op_a=%h op_b=%h result=%h cf=%b ovf=%b scf=%b sovf=%b cnt=%0d rv=%b busy=%b rdy=%b, required all 0 except din_ready=1",
                     name, op_a, op_b, result, res_cf, res_ovf, sticky_cf, sticky_ovf,
                     op_count, res_valid, busy, din_ready);
        end
    endtask

    task automatic test_reset();
        clr        = 1'b1;
        din        = 8'hA5;
        din_valid  = 1'b1;
        res_ready  = 1'b1;
        clr_sticky = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr       = 1'b0;
        din_valid = 1'b0;
        q.delete();
        exp_count = 8'd0;
        check_reset_values("reset");
    endtask

    task automatic test_basic();
        run_op(8'h7F, 8'h01);
        expect_result("basic_7f_01", 1);
        checks++;
        if (sticky_ovf !== 1'b1 || sticky_cf !== 1'b0) begin
            errors++;
            $display("FAIL basic_sticky: cf=%b ovf=%b, required 0/1", sticky_cf, sticky_ovf);
        end
    endtask

    task automatic test_flags();
        run_op(8'hFF, 8'h01);
        expect_result("flags_ff_01", 1);
        checks++;
        if (sticky_cf !== 1'b1) begin
            errors++;
            $display("FAIL flags_sticky_set: sticky_cf=%b, required 1", sticky_cf);
        end
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if (sticky_cf !== 1'b0 || sticky_ovf !== 1'b0) begin
            errors++;
            $display("FAIL flags_sticky_clear: cf=%b ovf=%b, required 0/0", sticky_cf, sticky_ovf);
        end
        run_op(8'h80, 8'h80);
        expect_result("flags_80_80", 1);
    endtask

    task automatic test_backpressure();
        exp_t e;
        res_ready = 1'b0;
        run_op(8'h3C, 8'h42);
        @(posedge clk); #1;
        e = q[0];
        for (int i = 0; i < 5; i++) begin
            din       = 8'h55;
            din_valid = 1'b1;
            checks++;
            if (result !== e.r || res_valid !== 1'b1 || din_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: result=%h rv=%b rdy=%b, required %h/1/0",
                         i, result, res_valid, din_ready, e.r);
            end
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        checks++;
        if (op_a !== 8'h3C || op_b !== 8'h42) begin
            errors++;
            $display("FAIL backpressure_operands: op_a=%h op_b=%h, required 3c/42", op_a, op_b);
        end
        res_ready = 1'b1;
        expect_result("backpressure_release", 0);
    endtask

    task automatic test_gap();
        q.push_back(model(8'h5A, 8'h27));
        send(8'h5A);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1 || din_ready !== 1'b1 || res_valid !== 1'b0 || op_a !== 8'h5A) begin
                errors++;
                $display("FAIL gap_wait[%0d]: busy=%b rdy=%b rv=%b op_a=%h, required 1/1/0/5a",
                         i, busy, din_ready, res_valid, op_a);
            end
        end
        send(8'h27);
        expect_result("gap_sum", 1);
    endtask

    task automatic test_clr_exec();
        test_reset();
        run_op(8'h12, 8'h34);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        void'(q.pop_back());
        check_reset_values("clr_exec");
        run_op(8'h20, 8'h22);
        expect_result("after_clr", 1);
    endtask

    task automatic test_wrap();
        test_reset();
        for (int i = 0; i < 255; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            expect_result("wrap_op", 1);
        end
        checks++;
        if (op_count !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: op_count=%0d, required 255", op_count);
        end
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if (sticky_cf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_preclear: sticky_cf=%b, required 0", sticky_cf);
        end
        run_op(8'hFF, 8'h01);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if (sticky_cf !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: sticky_cf=%b, required 1", sticky_cf);
        end
        expect_result("wrap_last", 0);
        checks++;
        if (op_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero: op_count=%0d, required 0", op_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_backpressure();
        test_gap();
        test_clr_exec();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
